ldpc_llr_loader: RTL
====================

LDPC_LLR_LOADER -- requirements
Module: ldpc_llr_loader

Interface
REQ-001 SHALL have parameter NUMVNS, default 3: LLR lanes per packed word; matches the downstream VN cluster.
REQ-002 SHALL have parameter FOLDFACTOR, default 1: the address width is 7+FOLDFACTOR.
REQ-003 SHALL have parameter LLRWIDTH, default 6: width of each stored LLR.
REQ-004 SHALL have parameter INWIDTH, default 8: width of each signed input sample, with INWIDTH >= LLRWIDTH.
REQ-005 SHALL have parameter NUMWORDS, default 128: words per codeword, with 1 <= NUMWORDS <= 2^(7+FOLDFACTOR).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: begins a codeword load and is honoured only in IDLE.
REQ-009 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-010 SHALL have port llr_in_valid, input, 1 bit: an input sample is present.
REQ-011 SHALL have port llr_in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-012 SHALL have port llr_in, input, INWIDTH bits: signed two's-complement channel sample.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port load_done, output, 1 bit: one-cycle pulse when the whole codeword has been written.
REQ-015 SHALL have port llr_access, output, 1 bit: claims the VN cluster LLR port.
REQ-016 SHALL have port llr_addr, output, 7+FOLDFACTOR bits: word address to the VN cluster.
REQ-017 SHALL have port llr_din_we, output, 1 bit: write strobe to the VN cluster.
REQ-018 SHALL have port llr_din, output, NUMVNS*LLRWIDTH bits: packed word; lane j occupies bits [LLRWIDTH*j+LLRWIDTH-1 : LLRWIDTH*j].

Function
REQ-019 SHALL implement the FSM states IDLE, FILL, WRITE and DONE.
REQ-020 IDLE: start=1 -> FILL; lane counter and word address cleared to 0.
REQ-021 SHALL make llr_in_ready = 1 only in FILL.
REQ-022 SHALL accept a sample only on a cycle with llr_in_valid && llr_in_ready; other cycles leave the lane counter and lanes unchanged.
REQ-023 SHALL store an accepted sample, saturated, in lane[lane counter], then increment the lane counter.
REQ-024 Saturation SHALL clamp to the symmetric range [-(2^(LLRWIDTH-1)-1), +(2^(LLRWIDTH-1)-1)]; in-range values pass unchanged and the most-negative code is never produced.
REQ-025 FILL: acceptance into lane NUMVNS-1 -> WRITE on the next cycle, with the lane counter reset to 0.
REQ-026 WRITE SHALL last exactly one cycle, with llr_din_we=1, llr_din = packed lanes and llr_addr = current word address.
REQ-027 WRITE: address == NUMWORDS-1 -> DONE; otherwise address+1 and -> FILL.
REQ-028 DONE SHALL last exactly one cycle, with load_done=1, then -> IDLE.
REQ-029 SHALL drive llr_access = 1 in FILL and WRITE, and 0 in IDLE and DONE.
REQ-030 SHALL register llr_din, llr_addr and llr_din_we as flops, not decode them combinationally from inputs.
REQ-031 Per-word cost SHALL be NUMVNS accepted samples plus one WRITE cycle; zero-bubble throughput SHALL be one word per NUMVNS+1 cycles.
REQ-032 SHALL ignore start outside IDLE.
REQ-033 abort in FILL or WRITE SHALL force IDLE next cycle, suppressing any WRITE not yet issued and any load_done pulse.
REQ-034 When abort and start are high together in IDLE, SHALL take abort: remain in IDLE.
REQ-035 After the final address the address SHALL NOT wrap; no write SHALL go beyond NUMWORDS-1.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, regardless of the clock.
REQ-037 rst=1 SHALL clear to 0: lane counter, address, lanes, llr_din, llr_din_we, llr_access, llr_in_ready, busy and load_done.
REQ-038 rst asserted mid-load SHALL discard the partial word with no write pulse; the next start begins again at address 0.

Verification (NUMVNS=3, LLRWIDTH=6, INWIDTH=8, NUMWORDS=4)
REQ-039 Reset with rst held: all outputs 0 without any clock edge; state IDLE.
REQ-040 start, then samples 1,2,3 back-to-back -> one cycle later llr_din_we=1, llr_addr=0, llr_din=18'h03081.
REQ-041 Samples 8'h7F, 8'h80, 8'hFB -> lanes 6'h1F, 6'h21, 6'h3B.
REQ-042 llr_in_valid toggled 1,0,1,0,1 -> exactly 3 accepts; write occurs only after the third accept.
REQ-043 12 samples streamed -> writes at addr 0,1,2,3; one load_done pulse the cycle after the addr-3 write; busy=0 the cycle after that; start during the load has no effect.
REQ-044 abort after 2 samples of word 1 -> no write; IDLE next cycle; no load_done; a fresh load then writes addr 0.

Source files
------------

// File: rtl/ldpc_llr_loader.sv
// Collects saturated channel LLRs into NUMVNS-lane words and writes one word per
// fill into the VN cluster LLR memory, walking addresses 0..NUMWORDS-1.
module ldpc_llr_loader #(
  parameter int NUMVNS     = 3,
  parameter int FOLDFACTOR = 1,
  parameter int LLRWIDTH   = 6,
  parameter int INWIDTH    = 8,
  parameter int NUMWORDS   = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         llr_in_valid,
  output logic                         llr_in_ready,
  input  logic [INWIDTH-1:0]           llr_in,
  output logic                         busy,
  output logic                         load_done,
  output logic                         llr_access,
  output logic [7+FOLDFACTOR-1:0]      llr_addr,
  output logic                         llr_din_we,
  output logic [NUMVNS*LLRWIDTH-1:0]   llr_din
);

  localparam int AW = 7 + FOLDFACTOR;
  localparam int CW = (NUMVNS > 1) ? $clog2(NUMVNS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Symmetric clamp: the most-negative LLR code is never produced.
  localparam logic signed [INWIDTH-1:0] SAT_MAX = INWIDTH'(2 ** (LLRWIDTH - 1) - 1);
  localparam logic signed [INWIDTH-1:0] SAT_MIN = -SAT_MAX;

  logic [1:0]                 state_reg, state_next;
  logic [CW-1:0]              lane_cnt_reg;
  logic [AW-1:0]              addr_reg;
  logic [NUMVNS*LLRWIDTH-1:0] din_reg;
  logic                       we_reg;

  logic signed [INWIDTH-1:0]  sample_s;
  logic [LLRWIDTH-1:0]        sat_val;
  logic [NUMVNS*LLRWIDTH-1:0] packed_next;
  logic                       accept;
  logic                       last_lane;
  logic                       last_addr;
  logic                       issue_write;

  assign llr_in_ready = (state_reg == FILL);
  assign busy         = (state_reg != IDLE);
  assign load_done    = (state_reg == DONE);
  assign llr_access   = (state_reg == FILL) || (state_reg == WRITE);
  assign llr_addr     = addr_reg;
  assign llr_din      = din_reg;
  assign llr_din_we   = we_reg;

  assign accept      = llr_in_valid && llr_in_ready;
  assign last_lane   = (lane_cnt_reg == CW'(NUMVNS - 1));
  assign last_addr   = (addr_reg == AW'(NUMWORDS - 1));
  assign issue_write = accept && last_lane && !abort;

  assign sample_s = $signed(llr_in);

  always_comb begin
    if (sample_s > SAT_MAX)
      sat_val = SAT_MAX[LLRWIDTH-1:0];
    else if (sample_s < SAT_MIN)
      sat_val = SAT_MIN[LLRWIDTH-1:0];
    else
      sat_val = sample_s[LLRWIDTH-1:0];
  end

  // The word registered for WRITE includes the sample accepted on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUMVNS; gi++) begin : g_lane
      logic                lane_reg;
      logic [LLRWIDTH-1:0] lane_val_reg;
      assign lane_reg = accept && (lane_cnt_reg == CW'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lane_val_reg <= '0;
        else if (lane_reg)
          lane_val_reg <= sat_val;
      end

      assign packed_next[gi*LLRWIDTH +: LLRWIDTH] = lane_reg ? sat_val : lane_val_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !abort) state_next = FILL;
      FILL:    if (abort) state_next = IDLE;
               else if (accept && last_lane) state_next = WRITE;
      WRITE:   if (abort) state_next = IDLE;
               else if (last_addr) state_next = DONE;
               else state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      lane_cnt_reg <= '0;
      addr_reg     <= '0;
      din_reg      <= '0;
      we_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= (state_reg == FILL) && issue_write;

      if ((state_reg == FILL) && issue_write)
        din_reg <= packed_next;

      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            lane_cnt_reg <= '0;
            addr_reg     <= '0;
          end
        end
        FILL: begin
          if (abort)
            lane_cnt_reg <= '0;
          else if (accept)
            lane_cnt_reg <= last_lane ? '0 : lane_cnt_reg + 1'b1;
        end
        WRITE: begin
          // Address stops at the last word; DONE follows instead of a wrap.
          if (!abort && !last_addr)
            addr_reg <= addr_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
